// File: rtl/a2d_pkg.sv
// a2d_pkg -- shared types and helpers for the A2D round sequencer.
//   state_e    : sequencer FSM states
//   sel_e      : which reading of the round is in progress
//   CH_*       : ADC channel numbers for left cell, right cell, battery
//   chnl_of()  : reading index -> ADC channel number
//   build_cmd(): ADC channel -> 16-bit SPI command word
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WAIT_CMD,
        GAP,
        READ,
        WAIT_RD
    } state_e;

    typedef enum logic [1:0] {
        SEL_LFT,
        SEL_RGHT,
        SEL_BATT
    } sel_e;

    localparam logic [2:0] CH_LFT  = 3'd0;
    localparam logic [2:0] CH_RGHT = 3'd4;
    localparam logic [2:0] CH_BATT = 3'd5;

    function automatic logic [2:0] chnl_of(input sel_e sel);
        logic [2:0] ch;
        case (sel)
            SEL_LFT:  ch = CH_LFT;
            SEL_RGHT: ch = CH_RGHT;
            default:  ch = CH_BATT;
        endcase
        return ch;
    endfunction

    function automatic logic [15:0] build_cmd(input logic [2:0] chnl);
        return {2'b00, chnl, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_seq.sv
// a2d_seq -- sequences one A2D conversion round over SPI: left cell (ch 0),
// right cell (ch 4), battery (ch 5). Each channel takes two SPI transactions;
// the first primes the ADC mux, the second returns the result.
//
// Parameters:
//   TIMEOUT : max cycles waited for SPI done before the round is aborted
//   PERIOD  : auto-round interval in clk cycles (A2D_SEQ_AUTO_EN only)
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   nxt                : pulse requesting one round (ignored while busy)
//   wrt                : one-cycle pulse launching an SPI transaction
//   cmd[15:0]          : SPI command word, stable from wrt until done
//   done               : SPI transaction-complete pulse
//   rd_data[15:0]      : SPI receive word, valid with done
//   lft_ld/rght_ld/batt: latest 12-bit readings
//   vld                : one-cycle pulse when a round completes
//   err                : sticky timeout flag, cleared only by reset
// Configuration:
//   A2D_SEQ_AUTO_EN    : when defined, an internal counter also starts a
//                        round every PERIOD cycles (dropped if busy).
module a2d_seq
    import a2d_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned PERIOD  = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        vld,
    output logic        err
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    sel_e          sel_q, sel_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          vld_q, vld_d;
    logic [11:0]   lft_q, lft_d;
    logic [11:0]   rght_q, rght_d;
    logic [11:0]   batt_q, batt_d;
    logic          start;

    // Only the 12-bit conversion result is meaningful.
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:12];

`ifdef A2D_SEQ_AUTO_EN
    localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);

    logic [PW-1:0] per_q;
    logic          auto_start;

    assign auto_start = (per_q == PER_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_q <= '0;
        end else begin
            per_q <= auto_start ? '0 : per_q + 1'b1;
        end
    end

    // Auto starts behave exactly like a port pulse: IDLE drops them when busy.
    assign start = nxt | auto_start;
`else
    assign start = nxt;
`endif

    // sel_q only advances on the final done of a channel, so cmd stays put
    // from wrt until the matching done without a separate holding register.
    assign cmd = build_cmd(chnl_of(sel_q));
    assign wrt = (state_q == CMD) || (state_q == READ);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tmo_d   = '0;
        err_d   = err_q;
        vld_d   = 1'b0;
        lft_d   = lft_q;
        rght_d  = rght_q;
        batt_d  = batt_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = CMD;
            end
            CMD: begin
                state_d = WAIT_CMD;
            end
            WAIT_CMD: begin
                if (done) begin
                    state_d = GAP;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    sel_d   = SEL_LFT;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            GAP: begin
                state_d = READ;
            end
            READ: begin
                state_d = WAIT_RD;
            end
            WAIT_RD: begin
                if (done) begin
                    case (sel_q)
                        SEL_LFT: begin
                            lft_d   = rd_data[11:0];
                            sel_d   = SEL_RGHT;
                            state_d = CMD;
                        end
                        SEL_RGHT: begin
                            rght_d  = rd_data[11:0];
                            sel_d   = SEL_BATT;
                            state_d = CMD;
                        end
                        default: begin
                            batt_d  = rd_data[11:0];
                            vld_d   = 1'b1;
                            sel_d   = SEL_LFT;
                            state_d = IDLE;
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    // Abort keeps whatever was captured earlier in the round.
                    state_d = IDLE;
                    sel_d   = SEL_LFT;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = SEL_LFT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= SEL_LFT;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            lft_q   <= '0;
            rght_q  <= '0;
            batt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            batt_q  <= batt_d;
        end
    end

    assign lft_ld  = lft_q;
    assign rght_ld = rght_q;
    assign batt    = batt_q;
    assign vld     = vld_q;
    assign err     = err_q;

endmodule
